jam_cost_table: RTL and testbench

- Responder end of the worker/job cost-lookup interface.
- Holds an N x N matrix of job costs, loaded serially in row-major order.
- Once loaded, returns the cost of worker W doing job J combinationally in the same cycle, so an assignment-search master can add Cost in the cycle it drives W/J.
- Tracks the search session: it stops serving when the master raises Valid, and can optionally count lookup cycles.

---
 rtl/jam_cost_table.sv | 91 +++++++++
 tb/tb_jam_cost_table.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_table.sv
// N x N job-cost matrix, loaded serially in row-major order and then read combinationally by W/J.
// Optional macro COSTTAB_ACCESS_CNT_EN adds a saturating SERVE-cycle counter on AccessCount.
module jam_cost_table #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Clear,
  input  logic          LoadEn,
  input  logic [CW-1:0] LoadData,
  output logic          Ready,
  input  logic [AW-1:0] W,
  input  logic [AW-1:0] J,
  output logic [CW-1:0] Cost,
  input  logic          Valid,
  output logic          Finished
`ifdef COSTTAB_ACCESS_CNT_EN
  ,
  output logic [19:0]   AccessCount
`endif
);

  localparam int DEPTH = N * N;
  localparam int PW    = $clog2(DEPTH);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] mat [DEPTH];
  logic [PW-1:0] rd_idx;
  logic          last_entry;
  logic          wr_en;

  assign last_entry = (wr_ptr == PW'(DEPTH - 1));
  assign wr_en      = !Clear && (state == S_LOAD) && LoadEn;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_LOAD;
      wr_ptr <= '0;
    end else if (Clear) begin
      state  <= S_LOAD;
      wr_ptr <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          // Valid is not looked at here, even on the final write.
          if (LoadEn) begin
            wr_ptr <= last_entry ? '0 : wr_ptr + PW'(1);
            if (last_entry) state <= S_SERVE;
          end
        end
        S_SERVE: if (Valid) state <= S_DONE;
        S_DONE:  state <= S_DONE;
        default: state <= S_LOAD;
      endcase
    end
  end

  // The matrix is cleared by reset but deliberately survives Clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mat[i] <= '0;
    end else if (wr_en) begin
      mat[wr_ptr] <= LoadData;
    end
  end

  assign rd_idx   = PW'(int'(W) * N + int'(J));
  assign Cost     = (state == S_LOAD) ? '0 : mat[rd_idx];
  assign Ready    = (state == S_SERVE);
  assign Finished = (state == S_DONE);

`ifdef COSTTAB_ACCESS_CNT_EN
  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == '1) ? v : v + 20'd1;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     AccessCount <= '0;
    else if (Clear)               AccessCount <= '0;
    else if (state == S_SERVE)    AccessCount <= sat_inc(AccessCount);
  end
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Randomized and directed bench for jam_cost_table against an array-based reference model.
// Build with +define+COSTTAB_ACCESS_CNT_EN to also check AccessCount.
module tb_jam_cost_table;
  localparam int N  = 8;
  localparam int CW = 7;
  localparam int AW = 3;
  localparam int CNT_MAX = 1048575;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Clear;
  logic          LoadEn;
  logic [CW-1:0] LoadData;
  logic          Ready;
  logic [AW-1:0] W;
  logic [AW-1:0] J;
  logic [CW-1:0] Cost;
  logic          Valid;
  logic          Finished;
`ifdef COSTTAB_ACCESS_CNT_EN
  logic [19:0]   AccessCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model: phase 0=loading, 1=serving, 2=finished
  int m_phase;
  int m_ptr;
  int m_cnt;
  int m_mat [N*N];

  always #5 CLK = ~CLK;

  jam_cost_table #(.N(N), .CW(CW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .Clear(Clear), .LoadEn(LoadEn), .LoadData(LoadData),
    .Ready(Ready), .W(W), .J(J), .Cost(Cost), .Valid(Valid), .Finished(Finished)
`ifdef COSTTAB_ACCESS_CNT_EN
    , .AccessCount(AccessCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < N*N; i++) m_mat[i] = 0;
  endtask

  task automatic model_step();
    if (!RST) begin
      model_reset();
    end else if (Clear) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (LoadEn) begin
        m_mat[m_ptr] = int'(LoadData);
        m_ptr++;
        if (m_ptr == N*N) begin m_ptr = 0; m_phase = 1; end
      end
    end else if (m_phase == 1) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (Valid) m_phase = 2;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, 32'(Ready), 32'(m_phase == 1));
    check({tag, ".finished"}, 32'(Finished), 32'(m_phase == 2));
    check({tag, ".cost"}, 32'(Cost), (m_phase == 0) ? 32'd0 : 32'(m_mat[int'(W)*N + int'(J)]));
`ifdef COSTTAB_ACCESS_CNT_EN
    check({tag, ".count"}, 32'(AccessCount), 32'(m_cnt));
`endif
  endtask

  // one clock: model follows the edge, returns on the following falling edge
  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    Clear = 0; LoadEn = 0; LoadData = '0; Valid = 0; W = '0; J = '0;
  endtask

  task automatic do_reset();
    RST = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
  endtask

  task automatic load_all(input int value, input bit use_k);
    for (int k = 0; k < N*N; k++) begin
      LoadEn = 1;
      LoadData = use_k ? CW'(k % 128) : CW'(value);
      cyc();
      check("load.ready", 32'(Ready), 32'(k == N*N-1));
    end
    LoadEn = 0;
  endtask

  int saved_cnt;
  int rdy_cycle;

  initial begin
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    do_reset();
    check_all("reset");

    // continuous load of k%128
    load_all(0, 1'b1);
    W = 3'd3; J = 3'd5; #1;
    check("w3j5", 32'(Cost), 32'd29);
    W = 3'd7; J = 3'd7; #1;
    check("w7j7", 32'(Cost), 32'd63);
    check_all("serve1");

    // gapped load: LoadEn only on even cycles
    do_reset();
    rdy_cycle = -1;
    for (int c = 0; c < 140 && rdy_cycle < 0; c++) begin
      LoadEn = (c % 2 == 0);
      LoadData = CW'((c / 2) % 128);
      cyc();
      if (Ready) rdy_cycle = c + 1;
    end
    LoadEn = 0;
    check("gap.ready_cycle", 32'(rdy_cycle), 32'd127);

    // zero-latency sweep with ignored loads
    for (int k = 0; k < N*N; k++) begin
      W = AW'(k / N); J = AW'(k % N);
      LoadEn = 1; LoadData = 7'd127;
      #1;
      check("sweep.cost", 32'(Cost), 32'(k % 128));
      check_all("sweep");
      cyc();
    end
    LoadEn = 0;

    // end the session
    Valid = 1;
    cyc();
    Valid = 0;
    check("valid.finished", 32'(Finished), 32'd1);
    check("valid.ready", 32'(Ready), 32'd0);
    check_all("done");
    saved_cnt = m_cnt;
    for (int i = 0; i < 100; i++) begin
      W = AW'($urandom_range(0, N-1)); J = AW'($urandom_range(0, N-1));
      Valid = 1'($urandom);
      LoadEn = 1'($urandom);
      cyc();
      check_all("frozen");
    end
    check("frozen.model_cnt", 32'(m_cnt), 32'(saved_cnt));
    idle_inputs();

    // partial load then clear, reload with 100
    Clear = 1; cyc(); Clear = 0;
    check_all("clear1");
    for (int k = 0; k < 30; k++) begin LoadEn = 1; LoadData = 7'd55; cyc(); end
    Clear = 1; LoadEn = 1; cyc(); Clear = 0;
    check_all("clear2");
    load_all(100, 1'b0);
    check_all("reload");
    for (int k = 0; k < N*N; k++) begin
      W = AW'(k / N); J = AW'(k % N); #1;
      check("reload.cost", 32'(Cost), 32'd100);
      check_all("reload.sweep");
      cyc();
    end

    // asynchronous reset in the middle of SERVE
    #2 RST = 0;
    model_reset();
    #1;
    check("areset.ready", 32'(Ready), 32'd0);
    check("areset.finished", 32'(Finished), 32'd0);
`ifdef COSTTAB_ACCESS_CNT_EN
    check("areset.count", 32'(AccessCount), 32'd0);
`endif
    @(negedge CLK);
    RST = 1;
    W = '0; J = '0;
    @(negedge CLK);
    check("areset.cost", 32'(Cost), 32'd0);
    check_all("areset");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Clear    = ($urandom_range(0, 199) == 0);
      LoadEn   = 1'($urandom);
      LoadData = CW'($urandom);
      Valid    = ($urandom_range(0, 39) == 0);
      W = AW'($urandom); J = AW'($urandom);
      #1;
      check_all("rand.comb");
      cyc();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1, expected 0");
    $fatal(1, "bench time limit reached");
  end
endmodule
